// File: rtl/dec_controller_pkg.sv
// dec_controller_pkg: shared constants, derived widths and the phase enum for the RS decoder
// beat controller.
//   RS_COD_LEN  - codeword length in symbols
//   RS_MES_LEN  - message length in symbols
//   RS_PAR_LEN  - parity length in symbols
//   DEC_SYM_NUM - symbols per input beat (1 < DEC_SYM_NUM < RS_PAR_LEN)
//   CW_DEPTH    - max completed codewords waiting for the corrector
//   SEQ_W       - codeword sequence-number width
package dec_controller_pkg;

    localparam int unsigned RS_COD_LEN  = 255;
    localparam int unsigned RS_MES_LEN  = 239;
    localparam int unsigned RS_PAR_LEN  = RS_COD_LEN - RS_MES_LEN;
    localparam int unsigned DEC_SYM_NUM = 8;
    localparam int unsigned CW_DEPTH    = 2;
    localparam int unsigned SEQ_W       = 4;

    localparam int unsigned CNT_W   = $clog2(RS_COD_LEN);
    // One extra bit so counter + DEC_SYM_NUM cannot overflow.
    localparam int unsigned EXT_W   = CNT_W + 1;
    localparam int unsigned SPLIT_W = $clog2(DEC_SYM_NUM + 1);
    localparam int unsigned OFF_W   = $clog2(DEC_SYM_NUM);
    localparam int unsigned PEND_W  = $clog2(CW_DEPTH + 1);

    typedef enum logic [2:0] {
        DEC_IDL,  // no beat accepted this cycle
        DEC_MES,  // all lanes are message symbols
        DEC_MTP,  // beat crosses from message into parity
        DEC_PAR,  // all lanes of the current codeword are parity
        DEC_PTM   // parity tail of one codeword, message head of the next
    } dec_phase_e;

endpackage

// File: rtl/dec_controller_if.sv
// dec_controller_if: input-beat handshake and corrector-release signals of the decoder controller.
//   in_valid - input beat valid            (master -> slave)
//   in_ready - input beat accepted         (slave  -> master)
//   cor_done - corrector released a codeword (master -> slave)
//   cor_fail - qualifies cor_done: uncorrectable (master -> slave)
interface dec_controller_if;

    logic in_valid;
    logic in_ready;
    logic cor_done;
    logic cor_fail;

    modport master (
        output in_valid,
        output cor_done,
        output cor_fail,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  cor_done,
        input  cor_fail,
        output in_ready
    );

endinterface

// File: rtl/dec_controller_credit.sv
// dec_controller_credit: count of completed codewords still waiting for the corrector, and the
// input-ready throttle derived from it. Optional uncorrectable-codeword counter when the macro
// DEC_CON_ERR_CNT_EN is defined.
//   clk_i        - clock
//   rst_ni       - synchronous active-low reset
//   inc_i        - a codeword was completed (accepted beat carrying its last symbol)
//   dec_i        - corrector released one codeword (ignored when nothing is pending)
//   fail_i       - qualifies dec_i as uncorrectable (DEC_CON_ERR_CNT_EN only)
//   err_count_o  - saturating uncorrectable count (DEC_CON_ERR_CNT_EN only)
//   pend_count_o - codewords pending correction
//   ready_o      - room for another codeword
module dec_controller_credit
    import dec_controller_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              dec_i,
`ifdef DEC_CON_ERR_CNT_EN
    input  logic              fail_i,
    output logic [15:0]       err_count_o,
`endif
    output logic [PEND_W-1:0] pend_count_o,
    output logic              ready_o
);

    logic [PEND_W-1:0] pend_q, pend_d;
    logic              dec_ok;

    assign dec_ok = dec_i & (pend_q != '0);

    // inc_i can only fire while ready_o is high, so pend_q never exceeds CW_DEPTH.
    always_comb begin
        pend_d = pend_q;
        if (inc_i && !dec_ok) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (!inc_i && dec_ok) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_count_o = pend_q;
    assign ready_o      = pend_q < PEND_W'(CW_DEPTH);

`ifdef DEC_CON_ERR_CNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (dec_ok && fail_i && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count_o = err_q;
`endif

endmodule

// File: rtl/dec_controller.sv
// dec_controller: beat-level controller for the parallel RS decoder. Tracks codeword boundaries
// in a stream of back-to-back codewords arriving DEC_SYM_NUM symbols per beat, drives lane-split
// and phase controls to the syndrome stage and message-extraction controls to the output
// gearbox, and throttles input with a credit of codewords awaiting the corrector.
// Optional feature macro: DEC_CON_ERR_CNT_EN adds err_count_o (uncorrectable codeword count).
//   clk_i         - clock
//   rst_ni        - synchronous active-low reset
//   bus_io        - handshake interface (in_valid/in_ready, cor_done/cor_fail)
//   con_counter_o - codeword index of lane 0 of the current beat
//   dec_phase_o   - beat phase (DEC_IDL when no beat is accepted)
//   syn_split_o   - lanes [0,split) belong to the current codeword
//   syn_start_o   - accepted beat holds symbol 0 of a codeword
//   syn_last_o    - accepted beat holds the last symbol of a codeword
//   mes_count_o   - message symbols in the beat
//   mes_offset_o  - lane of the first message symbol
//   cw_seq_o      - sequence number of the codeword closed by syn_last_o
//   err_count_o   - uncorrectable codewords, saturating (DEC_CON_ERR_CNT_EN only)
//   pend_count_o  - codewords pending correction
module dec_controller
    import dec_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    dec_controller_if.slave    bus_io,
    output logic [CNT_W-1:0]   con_counter_o,
    output dec_phase_e         dec_phase_o,
    output logic [SPLIT_W-1:0] syn_split_o,
    output logic               syn_start_o,
    output logic               syn_last_o,
    output logic [SPLIT_W-1:0] mes_count_o,
    output logic [OFF_W-1:0]   mes_offset_o,
    output logic [SEQ_W-1:0]   cw_seq_o,
`ifdef DEC_CON_ERR_CNT_EN
    output logic [15:0]        err_count_o,
`endif
    output logic [PEND_W-1:0]  pend_count_o
);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [EXT_W-1:0]   cnt_ext, nxt, rem;
    logic               acc, ready;
    logic               last_raw, ptm, mtp, par;
    logic [SPLIT_W-1:0] split;
    dec_phase_e         phase_raw;

    assign acc     = bus_io.in_valid & ready;
    assign cnt_ext = {1'b0, cnt_q};
    assign nxt     = cnt_ext + EXT_W'(DEC_SYM_NUM);
    assign rem     = EXT_W'(RS_COD_LEN) - cnt_ext;

    // The current codeword ends inside this beat.
    assign last_raw = nxt >= EXT_W'(RS_COD_LEN);
    assign split    = (rem < EXT_W'(DEC_SYM_NUM)) ? SPLIT_W'(rem) : SPLIT_W'(DEC_SYM_NUM);
    // Next codeword starts in the same beat.
    assign ptm      = last_raw & (rem < EXT_W'(DEC_SYM_NUM));
    assign mtp      = (cnt_ext < EXT_W'(RS_MES_LEN)) & (nxt > EXT_W'(RS_MES_LEN));
    assign par      = cnt_ext >= EXT_W'(RS_MES_LEN);

    always_comb begin
        phase_raw    = DEC_MES;
        mes_count_o  = SPLIT_W'(DEC_SYM_NUM);
        mes_offset_o = '0;
        if (ptm) begin
            phase_raw = DEC_PTM;
        end else if (mtp) begin
            phase_raw = DEC_MTP;
        end else if (par) begin
            phase_raw = DEC_PAR;
        end
        unique case (phase_raw)
            DEC_MTP: mes_count_o = SPLIT_W'(EXT_W'(RS_MES_LEN) - cnt_ext);
            DEC_PAR: mes_count_o = '0;
            DEC_PTM: begin
                // Head of the next codeword is all message since DEC_SYM_NUM < RS_MES_LEN.
                mes_count_o  = SPLIT_W'(DEC_SYM_NUM) - split;
                mes_offset_o = OFF_W'(split);
            end
            default: mes_count_o = SPLIT_W'(DEC_SYM_NUM);
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        seq_d = seq_q;
        if (acc) begin
            cnt_d = last_raw ? CNT_W'(nxt - EXT_W'(RS_COD_LEN)) : nxt[CNT_W-1:0];
            if (last_raw) begin
                seq_d = seq_q + SEQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            seq_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            seq_q <= seq_d;
        end
    end

    dec_controller_credit u_credit (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .inc_i        (acc & last_raw),
        .dec_i        (bus_io.cor_done),
`ifdef DEC_CON_ERR_CNT_EN
        .fail_i       (bus_io.cor_fail),
        .err_count_o  (err_count_o),
`endif
        .pend_count_o (pend_count_o),
        .ready_o      (ready)
    );

`ifndef DEC_CON_ERR_CNT_EN
    logic unused_cor_fail;
    assign unused_cor_fail = bus_io.cor_fail;
`endif

    assign bus_io.in_ready = ready;
    assign con_counter_o   = cnt_q;
    assign dec_phase_o     = acc ? phase_raw : DEC_IDL;
    assign syn_split_o     = split;
    assign syn_start_o     = acc & ((cnt_q == '0) | ptm);
    assign syn_last_o      = acc & last_raw;
    assign cw_seq_o        = seq_q;

endmodule

// File: tb/tb_dec_controller.sv
// tb_dec_controller: self-checking bench for dec_controller. A lane-level model of the symbol
// stream predicts every output each cycle; directed phases pin the model with literal values,
// followed by randomized valid/cor_done/cor_fail/reset traffic.
// Honours DEC_CON_ERR_CNT_EN the same way as the design.
module tb_dec_controller;
    import dec_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [CNT_W-1:0]   con_counter;
    dec_phase_e         dec_phase;
    logic [SPLIT_W-1:0] syn_split;
    logic               syn_start;
    logic               syn_last;
    logic [SPLIT_W-1:0] mes_count;
    logic [OFF_W-1:0]   mes_offset;
    logic [SEQ_W-1:0]   cw_seq;
    logic [PEND_W-1:0]  pend_count;
`ifdef DEC_CON_ERR_CNT_EN
    logic [15:0]        err_count;
`endif

    dec_controller_if bus ();

    dec_controller dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus_io        (bus),
        .con_counter_o (con_counter),
        .dec_phase_o   (dec_phase),
        .syn_split_o   (syn_split),
        .syn_start_o   (syn_start),
        .syn_last_o    (syn_last),
        .mes_count_o   (mes_count),
        .mes_offset_o  (mes_offset),
        .cw_seq_o      (cw_seq),
`ifdef DEC_CON_ERR_CNT_EN
        .err_count_o   (err_count),
`endif
        .pend_count_o  (pend_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: position of lane 0 inside its codeword, credits, sequence, errors.
    int m_cnt  = 0;
    int m_pend = 0;
    int m_seq  = 0;
    int m_err  = 0;
    bit m_ok   = 1'b0;
    bit m_last_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Expected outputs from a per-lane walk over the symbol stream.
    task automatic check_model();
        int         split, mes, moff, pos, idx;
        bit         cur, last, start, straddle, found, acc;
        dec_phase_e ph;
        if (!rst_n || !m_ok) return;
        split = 0; mes = 0; moff = 0;
        last = 1'b0; start = 1'b0; straddle = 1'b0; found = 1'b0;
        acc = bus.in_valid && (m_pend < CW_DEPTH);
        for (int k = 0; k < DEC_SYM_NUM; k++) begin
            pos = m_cnt + k;
            cur = pos < RS_COD_LEN;
            idx = cur ? pos : pos - RS_COD_LEN;
            if (cur) split++;
            if (cur && idx == RS_COD_LEN - 1) last = 1'b1;
            if (idx == 0) start = 1'b1;
            if (cur && idx == RS_MES_LEN && k > 0) straddle = 1'b1;
            if (idx < RS_MES_LEN) begin
                if (!found) moff = k;
                found = 1'b1;
                mes++;
            end
        end
        if (!acc) ph = DEC_IDL;
        else if (last && split < DEC_SYM_NUM) ph = DEC_PTM;
        else if (straddle) ph = DEC_MTP;
        else if (m_cnt >= RS_MES_LEN) ph = DEC_PAR;
        else ph = DEC_MES;
        chk("con_counter", 32'(con_counter), m_cnt);
        chk("in_ready", 32'(bus.in_ready), 32'(m_pend < CW_DEPTH));
        chk("dec_phase", 32'(dec_phase), 32'(ph));
        chk("syn_split", 32'(syn_split), split);
        chk("syn_start", 32'(syn_start), 32'(start && acc));
        chk("syn_last", 32'(syn_last), 32'(last && acc));
        chk("mes_count", 32'(mes_count), mes);
        chk("mes_offset", 32'(mes_offset), moff);
        chk("cw_seq", 32'(cw_seq), m_seq);
        chk("pend_count", 32'(pend_count), m_pend);
`ifdef DEC_CON_ERR_CNT_EN
        chk("err_count", 32'(err_count), m_err);
`endif
    endtask

    task automatic model_update();
        bit acc, last, done;
        if (!rst_n) begin
            m_cnt = 0; m_pend = 0; m_seq = 0; m_err = 0;
            m_ok = 1'b1; m_last_acc = 1'b0;
        end else if (m_ok) begin
            acc  = bus.in_valid && (m_pend < CW_DEPTH);
            last = acc && (m_cnt + DEC_SYM_NUM >= RS_COD_LEN);
            done = bus.cor_done && (m_pend > 0);
            if (acc) m_cnt = (m_cnt + DEC_SYM_NUM) % RS_COD_LEN;
            if (last) m_seq = (m_seq + 1) % (1 << SEQ_W);
            if (done && bus.cor_fail && m_err < 16'hFFFF) m_err++;
            m_pend = m_pend + int'(last) - int'(done);
            m_last_acc = last;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        int pulses;
        int frozen;
        bit hit;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.cor_done = 1'b0;
        bus.cor_fail = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;

        // Reset state
        settle();
        chk("rst_counter", 32'(con_counter), 0);
        chk("rst_pend", 32'(pend_count), 0);
        chk("rst_seq", 32'(cw_seq), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        advance();

        // Continuous stream, corrector releases one cycle after each syn_last
        bus.in_valid = 1'b1;
        pulses = 0;
        for (int b = 0; b < RS_COD_LEN; b++) begin
            bus.cor_done = m_last_acc;
            settle();
            if (syn_last === 1'b1) pulses++;
            case (b)
                1: chk("t1_counter8", 32'(con_counter), 8);
                29: begin
                    chk("t2_counter232", 32'(con_counter), 232);
                    chk("t2_mtp", 32'(dec_phase), 32'(DEC_MTP));
                    chk("t2_mtp_count", 32'(mes_count), 7);
                    chk("t2_mtp_offset", 32'(mes_offset), 0);
                end
                30: begin
                    chk("t2_par", 32'(dec_phase), 32'(DEC_PAR));
                    chk("t2_par_count", 32'(mes_count), 0);
                end
                31: begin
                    chk("t1_counter248", 32'(con_counter), 248);
                    chk("t1_split7", 32'(syn_split), 7);
                    chk("t1_ptm", 32'(dec_phase), 32'(DEC_PTM));
                    chk("t1_ptm_start", 32'(syn_start), 1);
                    chk("t1_ptm_last", 32'(syn_last), 1);
                    chk("t1_ptm_offset", 32'(mes_offset), 7);
                    chk("t1_ptm_count", 32'(mes_count), 1);
                end
                32: chk("t1_counter1", 32'(con_counter), 1);
                default: ;
            endcase
            advance();
        end
        bus.in_valid = 1'b0;
        bus.cor_done = m_last_acc;
        settle();
        chk("t3_counter0", 32'(con_counter), 0);
        chk("t3_seq8", 32'(cw_seq), 8);
        chk("t3_pulses8", pulses, 8);
        advance();

        // Credit exhaustion
        bus.cor_done = 1'b0;
        bus.in_valid = 1'b1;
        to = 0;
        while (m_pend < CW_DEPTH && to < 600) begin
            cyc();
            to++;
        end
        if (to >= 600) timeout_fail("t4_fill");
        settle();
        chk("t4_not_ready", 32'(bus.in_ready), 0);
        chk("t4_pend2", 32'(pend_count), 2);
        frozen = m_cnt;
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_frozen", 32'(con_counter), frozen);
            chk("t4_idle", 32'(dec_phase), 32'(DEC_IDL));
            advance();
        end
        bus.cor_done = 1'b1;
        cyc();
        bus.cor_done = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        chk("t4_ready_again", 32'(bus.in_ready), 1);
        chk("t4_pend1", 32'(pend_count), 1);
        advance();

        // syn_last and cor_done together with one pending
        bus.in_valid = 1'b1;
        to = 0;
        hit = 1'b0;
        while (!hit && to < 600) begin
            bus.cor_done = (m_cnt + DEC_SYM_NUM >= RS_COD_LEN);
            hit = bus.cor_done;
            settle();
            if (hit) chk("t5_last_seen", 32'(syn_last), 1);
            advance();
            to++;
        end
        if (!hit) timeout_fail("t5_find_last");
        bus.cor_done = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        chk("t5_pend_kept1", 32'(pend_count), 1);
        advance();
        bus.cor_done = 1'b1;
        cyc();
        cyc();
        bus.cor_done = 1'b0;
        settle();
        chk("t5_pend0_ignored", 32'(pend_count), 0);
        chk("t5_ready", 32'(bus.in_ready), 1);
        advance();

        // Reset mid-codeword at counter 120 with one codeword pending
        bus.in_valid = 1'b1;
        to = 0;
        while (!(m_cnt == 120 && m_pend == 1) && to < 2000) begin
            bus.cor_done = (m_pend == CW_DEPTH);
            cyc();
            to++;
        end
        if (to >= 2000) timeout_fail("t6_reach120");
        bus.cor_done = 1'b0;
        settle();
        chk("t6_at120", 32'(con_counter), 120);
        chk("t6_pend1", 32'(pend_count), 1);
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        settle();
        chk("t6_counter0", 32'(con_counter), 0);
        chk("t6_pend0", 32'(pend_count), 0);
        chk("t6_seq0", 32'(cw_seq), 0);
        chk("t6_ready", 32'(bus.in_ready), 1);
        chk("t6_idle", 32'(dec_phase), 32'(DEC_IDL));
        advance();
        bus.in_valid = 1'b1;
        settle();
        chk("t6_fresh_start", 32'(syn_start), 1);
        chk("t6_fresh_split", 32'(syn_split), 8);
        advance();

`ifdef DEC_CON_ERR_CNT_EN
        to = 0;
        while (m_err < 3 && to < 2000) begin
            bus.cor_done = (m_pend > 0);
            bus.cor_fail = bus.cor_done;
            cyc();
            to++;
        end
        if (to >= 2000) timeout_fail("t6_err_fill");
        bus.cor_done = 1'b0;
        bus.cor_fail = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        chk("t6_err3", 32'(err_count), 3);
        advance();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.cor_done = ($urandom_range(0, 29) == 0);
            bus.cor_fail = $urandom_range(0, 1) == 1;
            rst_n = ($urandom_range(0, 999) != 0);
            cyc();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.cor_done = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
